// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's redirect, instruction-memory and decode-side signals.
// imem handshake: imem_req rises with imem_addr; both hold steady until the cycle imem_ack
// is high (which may be the very cycle req rises); that cycle completes the transfer and
// imem_rdata is valid. Decode side: the head word moves on when instr_valid && !stall_d.
interface fetch_unit_if;
    logic [1:0]  if_pc_src;
    logic [31:0] if_pc_branch_in;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        addr_err;

    modport master (
        input  if_pc_src, if_pc_branch_in, stall_d, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr_d, pc_d, pc_plus4_d, addr_err
    );

    modport slave (
        output if_pc_src, if_pc_branch_in, stall_d, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr_d, pc_d, pc_plus4_d, addr_err
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the fetch PC, issues one outstanding imem request at a
// time and buffers returned words in a small FIFO feeding decode, flushed on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_f_q, pc_f_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic          gap_q, gap_d;
    logic          addr_err_q, addr_err_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic redirect, req, ack_fire, push, pop, head_valid;

    assign redirect   = (bus.if_pc_src == 2'b01);
    assign head_valid = (count_q != '0);
    // gap_q forces one idle cycle after every ack, so a new request never shares an ack cycle
    assign req        = !rst && !gap_q && (outstanding_q || (count_q < CW'(DEPTH)));
    assign ack_fire   = req && bus.imem_ack;
    assign push       = ack_fire && !discard_q && !redirect;
    assign pop        = head_valid && !bus.stall_d;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = outstanding_q ? req_addr_q : pc_f_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr_d     = head_valid ? ins_mem_q[rd_ptr_q] : '0;
    assign bus.pc_d        = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.pc_plus4_d  = head_valid ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;
    assign bus.addr_err    = addr_err_q;

    always_comb begin
        pc_f_d        = pc_f_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        gap_d         = 1'b0;
        addr_err_d    = 1'b0;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (ack_fire) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
            gap_d         = 1'b1;
        end else if (req && !outstanding_q) begin
            // latch the address so it survives a redirect that moves pc_f
            outstanding_d = 1'b1;
            req_addr_d    = pc_f_q;
        end

        if (push) begin
            pc_f_d = pc_f_q + 32'd4;
        end

        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pc_f_d     = {bus.if_pc_branch_in[31:2], 2'b00};
            addr_err_d = |bus.if_pc_branch_in[1:0];
            if (req && !bus.imem_ack) begin
                discard_d = 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q        <= RESET_PC;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            gap_q         <= 1'b0;
            addr_err_q    <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            gap_q         <= gap_d;
            addr_err_q    <= addr_err_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]  <= pc_f_q;
                ins_mem_q[wr_ptr_q] <= bus.imem_rdata;
            end
        end
    end
endmodule
